div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative 8-bit restoring divider sitting directly downstream of the register file.
//  Consumes datA_out (dividend, rs) and datB_out (divisor, rt) when a divide op issues.
//  Produces quotient/remainder and a one-cycle write-back request
//  (wr_en/wr_addr/dat_in) for the register file write port.
//  Multi-cycle; the decoder stalls issue while busy is high.
// PARAMETERS
//  W   8  operand/result width in bits; also the iteration count
//  pw  3  register address pointer width; must match the register file
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  start       in   1   issue request; sampled only when busy==0
//  rs_dat      in   W   dividend (from register file datA_out)
//  rt_dat      in   W   divisor (from register file datB_out)
//  dst_addr    in   pw  destination register pointer, captured with start
//  busy        out  1   high in RUN and DONE states
//  done        out  1   one-cycle pulse when results valid
//  quotient    out  W   quotient; held until next accepted start
//  remainder   out  W   remainder; held until next accepted start
//  wr_en       out  1   register file write enable; equals done
//  wr_addr     out  pw  captured dst_addr; held
//  wr_dat      out  W   quotient; feeds register file dat_in
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, wr_en=0; quotient, remainder, wr_dat=0; wr_addr=0; iteration counter=0.
//  - FSM states and transitions:
//    - IDLE -> RUN on start (busy==0): capture rs_dat, rt_dat, dst_addr; clear partial remainder; count=0.
//    - RUN: one restoring step per cycle.
//      - {rem,dvd} <<= 1.
//      - If rem>=divisor (W+1-bit compare): rem-=divisor, shift 1 into q; else shift 0.
//      - count++. After the W-th step -> DONE.
//    - DONE: done=wr_en=1 for exactly one cycle; quotient/remainder/wr_dat registered -> IDLE.
//  - Latency: start sampled at edge N; done high during cycle N+W+1; busy low again at edge N+W+2.
//  - Back-to-back: the earliest next accepted start is the edge at which busy is first low (N+W+2).
//  - start while busy (RUN or DONE) is ignored; operands are not recaptured; no error is flagged.
//  - rs_dat/rt_dat may change after the start edge; the captured copies are used.
//  - Divide by zero: no special case. The algorithm yields quotient={W{1}}, remainder=dividend, with normal latency.
//  - Dividend < divisor: quotient=0, remainder=dividend.
//  - Reset mid-operation (RUN or DONE): abort to IDLE next edge. No done/wr_en pulse. Outputs return to reset values.
//  - Arithmetic: the partial remainder is W+1 bits wide to avoid compare overflow; no carry-out is exported.
// CONFIGURATION
//  - Macro DIV_SIGNED_EN. Defined: signed two's-complement divide.
//    - Magnitudes are captured at start.
//    - The quotient is negated if the operand signs differ.
//    - The remainder takes the dividend's sign (truncating division).
//    - Divide by zero: quotient={W{1}} (-1), remainder=dividend.
//    - Most-negative / -1: quotient=most-negative (wraps), remainder=0.
//    - Latency is unchanged; sign fix-up is done in DONE.
//  - Not defined: unsigned divide only; no sign logic is synthesized.
// TESTING
//  1. Unsigned: start, rs=100, rt=7, dst=3 -> done after 9 cycles; quotient=14, remainder=2; wr_en pulse with wr_addr=3, wr_dat=14.
//  2. Divide by zero: rs=5, rt=0 -> quotient=8'hFF, remainder=5, normal latency, wr_en pulses.
//  3. Ignore while busy: start rs=200, rt=10; re-assert start with rs=9, rt=3 at cycle 4 -> single done; quotient=20, remainder=0; only one wr_en.
//  4. Reset mid-op: start rs=50, rt=5; reset at cycle 5 -> busy=0 next edge; no done/wr_en; outputs 0; new start rs=9, rt=4 -> quotient=2, remainder=1.
//  5. Sign handling, rs=8'h9C, rt=7:
//     - With DIV_SIGNED_EN -> quotient=8'hF2 (-14), remainder=8'hFE (-2).
//     - Without -> quotient=22, remainder=2.
//  6. Back-to-back: start again on the first busy-low edge -> both results are correct; done pulses are W+2 cycles apart.

Source files
------------

// File: rtl/div_unit.sv
// Iterative W-bit restoring divider feeding the register-file write port.
// Define DIV_SIGNED_EN for two's-complement (truncating) divide; default is unsigned.
module div_unit #(
    parameter int W  = 8,
    parameter int pw = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [W-1:0]  rs_dat_i,
    input  logic [W-1:0]  rt_dat_i,
    input  logic [pw-1:0] dst_addr_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  quotient_o,
    output logic [W-1:0]  remainder_o,
    output logic          wr_en_o,
    output logic [pw-1:0] wr_addr_o,
    output logic [W-1:0]  wr_dat_o
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  dvd_q,   dvd_d;
    logic [W-1:0]  dvs_q,   dvs_d;
    logic [W-1:0]  rem_q,   rem_d;
    logic [W-1:0]  quo_q,   quo_d;
    logic [W-1:0]  rmd_q,   rmd_d;
    logic [pw-1:0] addr_q,  addr_d;
`ifdef DIV_SIGNED_EN
    logic          qneg_q,  qneg_d;
    logic          rneg_q,  rneg_d;
    logic          dz_q,    dz_d;
`endif

    logic [W:0]    sh;
    logic          ge;
    logic [W-1:0]  dvd_step, rem_step, quo_fix, rmd_fix;

    // One restoring step: shift {rem,dvd} left, trial-subtract on a W+1-bit window.
    always_comb begin
        sh       = {rem_q, dvd_q[W-1]};
        ge       = (sh >= {1'b0, dvs_q});
        rem_step = ge ? W'(sh - {1'b0, dvs_q}) : sh[W-1:0];
        dvd_step = {dvd_q[W-2:0], ge};
`ifdef DIV_SIGNED_EN
        quo_fix  = dz_q ? {W{1'b1}} : (qneg_q ? -dvd_step : dvd_step);
        rmd_fix  = rneg_q ? -rem_step : rem_step;
`else
        quo_fix  = dvd_step;
        rmd_fix  = rem_step;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        addr_d  = addr_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    addr_d  = dst_addr_i;
`ifdef DIV_SIGNED_EN
                    dvd_d   = rs_dat_i[W-1] ? -rs_dat_i : rs_dat_i;
                    dvs_d   = rt_dat_i[W-1] ? -rt_dat_i : rt_dat_i;
                    qneg_d  = rs_dat_i[W-1] ^ rt_dat_i[W-1];
                    rneg_d  = rs_dat_i[W-1];
                    dz_d    = (rt_dat_i == '0);
`else
                    dvd_d   = rs_dat_i;
                    dvs_d   = rt_dat_i;
`endif
                end
            end
            S_RUN: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                // Results land together with the DONE state so wr_dat is valid with wr_en.
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DONE;
                    quo_d   = quo_fix;
                    rmd_d   = rmd_fix;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            addr_q  <= '0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            addr_q  <= addr_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign wr_en_o     = done_o;
    assign quotient_o  = quo_q;
    assign wr_dat_o    = quo_q;
    assign remainder_o = rmd_q;
    assign wr_addr_o   = addr_q;
endmodule
